axi_pmu_sampler: RTL

//  Downstream consumer of the AXI PMU counter bank. The PMU exposes 19 x 64-bit counters
//  via pmu_addr_o -> pmu_data_i; its read port is combinational, so data is valid the same cycle.
//  On a trigger (periodic timer or software pulse), it snapshots all counters into a local buffer.
//  It then emits the snapshot as one AXI-Stream frame for the NoC trace/export path.

---
 rtl/axi_pmu_sampler_if.sv | 10 +
 rtl/axi_pmu_sampler.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/axi_pmu_sampler_if.sv
// rtl/axi_pmu_sampler_if.sv - AXI-Stream style snapshot export channel
interface axi_pmu_sampler_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axi_pmu_sampler.sv
// rtl/axi_pmu_sampler.sv - PMU counter snapshot engine with AXI-Stream frame export
module axi_pmu_sampler #(
  parameter int NUM_COUNTERS = 19,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable_i,
  input  logic [PERIOD_WIDTH-1:0] period_i,
  input  logic                    trigger_i,
  output logic [4:0]              pmu_addr_o,
  input  logic [63:0]             pmu_data_i,
  axi_pmu_sampler_if.master       m,
  output logic                    busy_o,
  output logic [15:0]             dropped_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HEADER  = 2'd2,
    ST_STREAM  = 2'd3
  } state_t;

  localparam logic [4:0]              LAST_IDX  = 5'(NUM_COUNTERS - 1);
  localparam logic [5:0]              LAST_BEAT = 6'(2 * NUM_COUNTERS - 1);
  localparam logic [PERIOD_WIDTH-1:0] TMR_ONE   = PERIOD_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] timer_q;
  logic [4:0]              idx_q;
  logic [5:0]              beat_q;
  logic [15:0]             seq_q;
  logic [15:0]             dropped_q;
  logic [63:0]             snap_q [NUM_COUNTERS];

  logic tmr_run_w;
  logic expiry_w;
  logic event_w;
  logic drop_w;
  logic hs_w;
  logic last_hs_w;

  assign tmr_run_w = enable_i && (period_i != '0);
  // >= rather than == so a period lowered below the running count still fires
  assign expiry_w  = tmr_run_w && (timer_q >= (period_i - TMR_ONE));
  assign event_w   = trigger_i || expiry_w;
  assign drop_w    = event_w && (state_q != ST_IDLE) && (dropped_q != 16'hFFFF);
  assign hs_w      = m.tvalid && m.tready;
  assign last_hs_w = hs_w && (state_q == ST_STREAM) && (beat_q == LAST_BEAT);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (event_w) state_d = ST_CAPTURE;
      ST_CAPTURE: if (idx_q == LAST_IDX) state_d = ST_HEADER;
      ST_HEADER:  if (m.tready) state_d = ST_STREAM;
      ST_STREAM:  if (last_hs_w) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pmu_addr_o = 5'd0;
    m.tvalid   = 1'b0;
    m.tdata    = 32'd0;
    m.tlast    = 1'b0;
    busy_o     = (state_q != ST_IDLE);
    case (state_q)
      ST_CAPTURE: pmu_addr_o = idx_q;
      ST_HEADER: begin
        m.tvalid = 1'b1;
        m.tdata  = {8'hA5, 8'(NUM_COUNTERS), seq_q};
      end
      ST_STREAM: begin
        m.tvalid = 1'b1;
        m.tdata  = beat_q[0] ? snap_q[beat_q[5:1]][63:32] : snap_q[beat_q[5:1]][31:0];
        m.tlast  = (beat_q == LAST_BEAT);
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_q <= '0;
    end else if (!tmr_run_w || expiry_w) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TMR_ONE;
    end
  end

  // Only written on a real drop so the count is left alone on every other cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dropped_q <= 16'd0;
    end else if (drop_w) begin
      dropped_q <= dropped_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idx_q  <= 5'd0;
      beat_q <= 6'd0;
      seq_q  <= 16'd0;
      for (int i = 0; i < NUM_COUNTERS; i++) snap_q[i] <= 64'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          idx_q  <= 5'd0;
          beat_q <= 6'd0;
        end
        ST_CAPTURE: begin
          snap_q[idx_q] <= pmu_data_i;
          idx_q         <= (idx_q == LAST_IDX) ? 5'd0 : idx_q + 5'd1;
        end
        ST_STREAM: begin
          if (last_hs_w) begin
            beat_q <= 6'd0;
            seq_q  <= seq_q + 16'd1;
          end else if (hs_w) begin
            beat_q <= beat_q + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dropped_cnt_o = dropped_q;

endmodule
